// File: rtl/cla_multiword_seq_if.sv
// Request/result bundle and external 16-bit adder bus
// for the multiword carry-lookahead add sequencer.
interface cla_multiword_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic          start;
  logic          ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          cin;
  logic [W-1:0]  sum;
  logic          cout;
  logic          done;
  logic [15:0]   cla_a;
  logic [15:0]   cla_b;
  logic          cla_cin;
  logic [15:0]   cla_s;
  logic          cla_cout;

  modport master (
    output start, in_a, in_b, cin, cla_s, cla_cout,
    input  ready, sum, cout, done, cla_a, cla_b, cla_cin
  );

  modport slave (
    input  start, in_a, in_b, cin, cla_s, cla_cout,
    output ready, sum, cout, done, cla_a, cla_b, cla_cin
  );
endinterface

// File: rtl/cla_multiword_seq.sv
// Wide adder built by time-multiplexing one 16-bit CLA,
// LSB slice first, carry chained through a register.
module cla_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                 CLK,
  input  logic                 reset,
  cla_multiword_seq_if.slave   bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nx;
  logic [W+15:0]   acc_cat;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            last;
  logic            run;

  assign run  = (state_q == RUN);
  assign last = (idx == IW'(WORDS - 1));

  // Slices enter at the top and shift down, so after
  // WORDS cycles slice 0 sits in the low 16 bits.
  assign acc_cat = {bus.cla_s, acc};
  assign acc_nx  = acc_cat[W+15:16];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            opa   <= bus.in_a;
            opb   <= bus.in_b;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          carry <= bus.cla_cout;
          opa   <= opa >> 16;
          opb   <= opb >> 16;
          idx   <= idx + 1'b1;
          if (last) begin
            sum_q  <= acc_nx;
            cout_q <= bus.cla_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.cla_a   = run ? opa[15:0] : 16'h0;
  assign bus.cla_b   = run ? opb[15:0] : 16'h0;
  assign bus.cla_cin = run & carry;
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed and randomized checks for cla_multiword_seq
// with a behavioral 16-bit adder on the slice bus.
module tb_cla_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic CLK;
  logic reset;
  int   checks;
  int   errors;

  cla_multiword_seq_if #(.WORDS(WORDS)) bus ();

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign {bus.cla_cout, bus.cla_s} =
    {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + {16'h0, bus.cla_cin};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Runs one op from an IDLE negedge and checks every
  // slice presented to the adder plus the final result.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c);
    logic [W:0]  exp;
    logic [16:0] s;
    logic        cc;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    bus.in_a  = a;
    bus.in_b  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    cc = c;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge CLK);
      check("cla_a", bus.cla_a, a[16*i +: 16]);
      check("cla_b", bus.cla_b, b[16*i +: 16]);
      check("cla_cin", bus.cla_cin, cc);
      check("run_ready", bus.ready, 1'b0);
      check("run_done", bus.done, 1'b0);
      s  = {1'b0, a[16*i +: 16]} + {1'b0, b[16*i +: 16]} + {16'h0, cc};
      cc = s[16];
    end
    @(negedge CLK);
    check("done", bus.done, 1'b1);
    check("sum", bus.sum, exp[W-1:0]);
    check("cout", bus.cout, exp[W]);
    check("done_cla_a", bus.cla_a, 16'h0);
    @(negedge CLK);
    check("post_done", bus.done, 1'b0);
    check("post_ready", bus.ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   rexp;
    int           ndone;

    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.cin   = 1'b0;

    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_sum", bus.sum, 64'h0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_cla_a", bus.cla_a, 16'h0);
    check("rst_cla_b", bus.cla_b, 16'h0);
    check("rst_cla_cin", bus.cla_cin, 1'b0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);

    // Second start during RUN must be ignored.
    bus.in_a  = 64'd1;
    bus.in_b  = 64'd1;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    @(negedge CLK);
    bus.in_a  = 64'd5;
    bus.in_b  = 64'd5;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (2) @(negedge CLK);
    check("ign_not_yet", bus.done, 1'b0);
    @(negedge CLK);
    check("ign_done", bus.done, 1'b1);
    check("ign_sum", bus.sum, 64'd2);
    @(negedge CLK);
    check("ign_ready", bus.ready, 1'b1);
    ndone = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.done) ndone++;
    end
    check("ign_extra_done", ndone, 0);
    check("ign_sum_hold", bus.sum, 64'd2);

    // Abort at idx==2.
    bus.in_a  = 64'h0000_0000_0000_FFFF;
    bus.in_b  = 64'h0000_0000_0000_0001;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    #1;
    check("abort_sum", bus.sum, 64'h0);
    check("abort_cout", bus.cout, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_ready", bus.ready, 1'b1);
    check("abort_cla_b", bus.cla_b, 16'h0);
    ndone = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.done) ndone++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(64'd3, 64'd4, 1'b1);

    // Back-to-back with start held high.
    bus.start = 1'b1;
    for (int n = 0; n < 500; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      bus.in_a = ra;
      bus.in_b = rb;
      bus.cin  = rc;
      rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      for (int j = 1; j <= WORDS + 2; j++) begin
        @(negedge CLK);
        if (j == 1) begin
          bus.in_a = ~ra;
          bus.in_b = ~rb;
        end
        if (j == WORDS + 1) begin
          check("b2b_done", bus.done, 1'b1);
          check("b2b_sum", bus.sum, rexp[W-1:0]);
          check("b2b_cout", bus.cout, rexp[W]);
        end else begin
          check("b2b_idle_done", bus.done, 1'b0);
        end
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_multiword_seq.md
Name: cla_multiword_seq

Overview:
Sequencer that performs wide (16*WORDS-bit) addition by time-multiplexing one external 16-bit carry-lookahead adder (cla_16bit), one 16-bit slice per clock, LSB slice first. It latches the operands on a start handshake, drives the adder slice by slice, and carries cout into the next slice's cin through a register. It then presents the full sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and a single cla_16bit instance, so wide adds need no wider adder.

Parameters:
WORDS, 4, number of 16-bit slices; total operand width W = 16*WORDS; legal range 1..16

Ports:
CLK  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  request; sampled only when ready=1
ready  output  1  1 when idle and able to accept start
in_a  input  W  operand A, sampled on accepted start
in_b  input  W  operand B, sampled on accepted start
cin  input  1  carry-in to slice 0, sampled on accepted start
cla_a  output  16  slice of A to adder
cla_b  output  16  slice of B to adder
cla_cin  output  1  carry-in to adder
cla_s  input  16  adder sum, combinational from cla_a/cla_b/cla_cin
cla_cout  input  1  adder carry-out
sum  output  W  registered result
cout  output  1  registered final carry-out
done  output  1  one-cycle pulse: sum/cout valid for the new result

Behaviour:
- Reset (reset=0, async): state=IDLE; ready=1; done=0; sum=0; cout=0; cla_a=0, cla_b=0, cla_cin=0; slice index=0; internal operand/accumulator registers=0.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On an edge with start=1:
  - load opa<=in_a, opb<=in_b, carry<=cin, idx<=0.
  - go to RUN.
  - When start=0, stay in IDLE.
- RUN: ready=0.
  - cla_a=opa[15:0], cla_b=opb[15:0], cla_cin=carry. All are driven from registers, with no combinational path from the inputs.
  - Each edge: acc slice idx <= cla_s; carry<=cla_cout; opa, opb shift right by 16; idx<=idx+1.
  - The edge with idx==WORDS-1 also loads sum<=final acc (including this slice's cla_s), loads cout<=cla_cout, and goes to DONE.
  - RUN lasts exactly WORDS cycles. WORDS=1 gives a single RUN cycle.
- DONE: done=1 for exactly this cycle; ready=0; cla_a/cla_b/cla_cin=0. Next edge returns to IDLE unconditionally.
- Outside RUN: cla_a=0, cla_b=0, cla_cin=0.
- Latency: start accepted at edge k, then done=1 in the cycle after edge k+WORDS. Minimum start-to-start spacing is WORDS+2 cycles.
- start while ready=0: ignored; no effect on the in-flight operation or the latched operands.
- start held high continuously: back-to-back operations, re-accepted on the first edge in IDLE.
- sum/cout: hold the previous result from DONE entry until the next DONE entry. They never show partial slices. in_a/in_b/cin changes after acceptance have no effect.
- Arithmetic: {cout,sum} == in_a + in_b + cin, modulo 2^(W+1); unsigned; overflow only via cout.
- Reset mid-operation (any state): immediate abort to reset values. No done is issued for the aborted operation. sum/cout read 0. The first start after reset release is accepted normally.
- idx width: ceil(log2(WORDS)), minimum 1 bit; no wrap is reachable in RUN.

Test Plan:
- Assert reset=0 for 2 cycles, release -> ready=1, done=0, sum=0, cout=0, cla_a=cla_b=0, cla_cin=0.
- WORDS=4, in_a=64'hFFFF_FFFF_FFFF_FFFF, in_b=0, cin=1 -> cla_cin sequence 1,1,1,1 over the 4 RUN cycles; done 5 cycles after accept; sum=0, cout=1.
- in_a=64'h0001_0002_0003_0004, in_b=64'h0010_0020_0030_0040, cin=0 -> cla_a sequence 0004,0003,0002,0001; cla_b sequence 0040,0030,0020,0010; sum=64'h0011_0022_0033_0044, cout=0.
- Start op A (1+1, cin=0); pulse start with in_a=5, in_b=5 during RUN -> second request ignored; single done with sum=2; ready returns 1 one cycle after done.
- Drive reset=0 mid-edge while idx=2 of op 0xFFFF+0x0001 -> outputs zero immediately, no done. After release, op 3+4 with cin=1 -> sum=8, cout=0.
- 500 random ops, operands full-range 64-bit, cin random, start held high -> every done matches {cout,sum}==a+b+cin; done spacing exactly 6 cycles; no done without an accepted start.
